// File: rtl/data_assembly_register_if.sv
// rtl/data_assembly_register_if.sv - control/data bundle between a byte producer and the assembly register
interface data_assembly_register_if #(
  parameter int BYTES = 4
);
  localparam int W  = 8 * BYTES;
  localparam int CW = $clog2(BYTES);

  logic          E;
  logic [2:0]    FunSel;
  logic [7:0]    I;
  logic          out_ready;
  logic [W-1:0]  DROut;
  logic [CW-1:0] Count;
  logic          WordValid;
  logic          Overflow;

  modport master (
    output E, FunSel, I, out_ready,
    input  DROut, Count, WordValid, Overflow
  );

  modport slave (
    input  E, FunSel, I, out_ready,
    output DROut, Count, WordValid, Overflow
  );
endinterface

// File: rtl/data_assembly_register.sv
// rtl/data_assembly_register.sv - byte-wide load/shift register with LE/BE word assembly and a valid/ready output
module data_assembly_register #(
  parameter int BYTES = 4
) (
  input  logic                    Clock,
  input  logic                    rst,
  data_assembly_register_if.slave bus
);
  localparam int W  = 8 * BYTES;
  localparam int CW = $clog2(BYTES);
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  logic [W-1:0]  r_dr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic          r_ovf;

  logic [W-1:0]  w_dr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_valid_nxt;
  logic          w_ovf_nxt;
  logic          w_accept;
  logic          w_blocked;
  logic [CW-1:0] w_lane;

  // A completed word is taken when valid meets ready; a pending word with no
  // consumer blocks further assembly bytes.
  assign w_accept  = r_valid & bus.out_ready;
  assign w_blocked = r_valid & ~bus.out_ready;
  assign w_lane    = bus.FunSel[0] ? (LAST - r_count) : r_count;

  // Next-state selection: mode decode, byte-lane assembly and handshake.
  always_comb begin
    w_dr_nxt    = r_dr;
    w_count_nxt = r_count;
    w_valid_nxt = r_valid & ~w_accept;
    w_ovf_nxt   = 1'b0;
    if (bus.E) begin
      case (bus.FunSel)
        3'b000: begin
          w_dr_nxt    = {{(W-8){bus.I[7]}}, bus.I};
          w_count_nxt = '0;
          w_valid_nxt = 1'b0;
        end
        3'b001: begin
          w_dr_nxt    = {{(W-8){1'b0}}, bus.I};
          w_count_nxt = '0;
          w_valid_nxt = 1'b0;
        end
        3'b010: begin
          w_dr_nxt    = {r_dr[W-9:0], bus.I};
          w_count_nxt = '0;
          w_valid_nxt = 1'b0;
        end
        3'b011: begin
          w_dr_nxt    = {bus.I, r_dr[W-1:8]};
          w_count_nxt = '0;
          w_valid_nxt = 1'b0;
        end
        3'b100, 3'b101: begin
          if (w_blocked) begin
            // Pending word not consumed: drop the byte and flag it.
            w_ovf_nxt = 1'b1;
          end else begin
            // The first byte of a word starts from a clean register.
            w_dr_nxt = (r_count == '0) ? '0 : r_dr;
            w_dr_nxt[8*w_lane +: 8] = bus.I;
            if (r_count == LAST) begin
              w_count_nxt = '0;
              w_valid_nxt = 1'b1;
            end else begin
              w_count_nxt = r_count + 1'b1;
            end
          end
        end
        3'b110: begin
          w_count_nxt = '0;
          w_valid_nxt = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge Clock) begin
    if (rst) begin
      r_dr    <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_dr    <= w_dr_nxt;
      r_count <= w_count_nxt;
      r_valid <= w_valid_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign bus.DROut     = r_dr;
  assign bus.Count     = r_count;
  assign bus.WordValid = r_valid;
  assign bus.Overflow  = r_ovf;
endmodule

// File: tb/tb_data_assembly_register.sv
// tb/tb_data_assembly_register.sv - directed self-checking bench for data_assembly_register
module tb_data_assembly_register;
  logic Clock;
  logic rst;
  int   tests;
  int   fails;

  data_assembly_register_if #(.BYTES(4)) bus ();

  data_assembly_register #(.BYTES(4)) dut (
    .Clock (Clock),
    .rst   (rst),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [2:0] fs, input logic [7:0] data);
    bus.E      = 1'b1;
    bus.FunSel = fs;
    bus.I      = data;
    tick();
    bus.E      = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) op(3'b100, w[8*k +: 8]);
  endtask

  task automatic idle();
    bus.E = 1'b0;
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst           = 1'b1;
    bus.E         = 1'b0;
    bus.FunSel    = 3'b000;
    bus.I         = 8'h00;
    bus.out_ready = 1'b0;
    tick();
    check("rst_drout", bus.DROut, 32'h0);
    check("rst_count", {30'h0, bus.Count}, 32'h0);
    check("rst_valid", {31'h0, bus.WordValid}, 32'h0);
    check("rst_ovf",   {31'h0, bus.Overflow}, 32'h0);
    rst = 1'b0;

    // Load/shift modes from 0x12345678 with I=0x9A
    load_word(32'h12345678);
    check("preload", bus.DROut, 32'h12345678);
    op(3'b000, 8'h9A);
    check("sext", bus.DROut, 32'hFFFFFF9A);
    check("sext_valid", {31'h0, bus.WordValid}, 32'h0);
    load_word(32'h12345678);
    op(3'b001, 8'h9A);
    check("zext", bus.DROut, 32'h0000009A);
    load_word(32'h12345678);
    op(3'b010, 8'h9A);
    check("shl", bus.DROut, 32'h3456789A);
    load_word(32'h12345678);
    op(3'b011, 8'h9A);
    check("shr", bus.DROut, 32'h9A123456);
    check("shr_count", {30'h0, bus.Count}, 32'h0);

    // Little-endian assembly, no consumer
    op(3'b100, 8'h11);
    check("le_first", bus.DROut, 32'h00000011);
    check("le_count1", {30'h0, bus.Count}, 32'h1);
    op(3'b100, 8'h22);
    op(3'b100, 8'h33);
    op(3'b100, 8'h44);
    check("le_word", bus.DROut, 32'h44332211);
    check("le_valid", {31'h0, bus.WordValid}, 32'h1);
    check("le_count0", {30'h0, bus.Count}, 32'h0);
    check("le_ovf0", {31'h0, bus.Overflow}, 32'h0);

    // Blocked write while word pending
    op(3'b100, 8'h55);
    check("blk_drout", bus.DROut, 32'h44332211);
    check("blk_ovf", {31'h0, bus.Overflow}, 32'h1);
    check("blk_count", {30'h0, bus.Count}, 32'h0);
    check("blk_valid", {31'h0, bus.WordValid}, 32'h1);
    idle();
    check("ovf_pulse_end", {31'h0, bus.Overflow}, 32'h0);
    check("hold_valid", {31'h0, bus.WordValid}, 32'h1);
    bus.out_ready = 1'b1;
    idle();
    check("accept_clr", {31'h0, bus.WordValid}, 32'h0);
    bus.out_ready = 1'b0;

    // Big-endian assembly
    op(3'b101, 8'h11);
    op(3'b101, 8'h22);
    op(3'b101, 8'h33);
    op(3'b101, 8'h44);
    check("be_word", bus.DROut, 32'h11223344);
    check("be_valid", {31'h0, bus.WordValid}, 32'h1);

    // Assembly concurrent with acceptance; final byte sets valid again
    bus.out_ready = 1'b1;
    op(3'b100, 8'hA1);
    check("acc_wr_drout", bus.DROut, 32'h000000A1);
    check("acc_wr_valid", {31'h0, bus.WordValid}, 32'h0);
    check("acc_wr_ovf", {31'h0, bus.Overflow}, 32'h0);
    op(3'b100, 8'hB2);
    op(3'b100, 8'hC3);
    check("acc_count3", {30'h0, bus.Count}, 32'h3);
    op(3'b100, 8'hD4);
    check("final_valid", {31'h0, bus.WordValid}, 32'h1);
    check("final_word", bus.DROut, 32'hD4C3B2A1);
    idle();
    check("final_accept", {31'h0, bus.WordValid}, 32'h0);
    bus.out_ready = 1'b0;

    // Reserved and abort
    op(3'b100, 8'h01);
    op(3'b100, 8'h02);
    op(3'b111, 8'hFF);
    check("rsv_drout", bus.DROut, 32'h00000201);
    check("rsv_count", {30'h0, bus.Count}, 32'h2);
    op(3'b110, 8'hFF);
    check("abort_count", {30'h0, bus.Count}, 32'h0);
    check("abort_drout", bus.DROut, 32'h00000201);
    check("abort_valid", {31'h0, bus.WordValid}, 32'h0);

    // Reset mid-assembly
    op(3'b100, 8'hEE);
    op(3'b100, 8'hFF);
    check("pre_rst", bus.DROut, 32'h0000FFEE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_drout", bus.DROut, 32'h0);
    check("mid_rst_count", {30'h0, bus.Count}, 32'h0);
    check("mid_rst_valid", {31'h0, bus.WordValid}, 32'h0);
    check("mid_rst_ovf", {31'h0, bus.Overflow}, 32'h0);
    op(3'b100, 8'hAB);
    check("post_rst_drout", bus.DROut, 32'h000000AB);
    check("post_rst_count", {30'h0, bus.Count}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
